// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative RV32M
// multiply/divide unit.
//   mulsel_e       - funct3 encoding of the M-extension operations
//   muldiv_state_e - control FSM states
//   MD_STEPS       - number of radix-2 iterations per operation
//   MD_CNT_W       - width of the iteration counter
//   abs32          - magnitude of a value that may be two's complement
package muldiv_pkg;

  localparam int MD_STEPS = 32;
  localparam int MD_CNT_W = 6;

  typedef enum logic [2:0] {
    MS_MUL    = 3'b000,
    MS_MULH   = 3'b001,
    MS_MULHSU = 3'b010,
    MS_MULHU  = 3'b011,
    MS_DIV    = 3'b100,
    MS_DIVU   = 3'b101,
    MS_REM    = 3'b110,
    MS_REMU   = 3'b111
  } mulsel_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  // Magnitude of v; only negated when the operand is read as signed.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide responder.
// One radix-2 step per cycle over 32 cycles; divide-by-zero and signed
// overflow finish in a single cycle.
// Ports:
//   clk        system clock
//   Rst        asynchronous active-low reset
//   start      request strobe (operands and mulsel sampled on acceptance)
//   mulsel     funct3 operation select
//   op_a/op_b  rs1/rs2 operands
//   flush      abort any in-flight operation
//   mul_ready  high when no operation is outstanding
//   busy       high while iterating
//   done       one-cycle pulse, result valid
//   result     32-bit result, held until the next completion
//   state_dbg  current FSM state (muldiv_state_e encoding)
//
// Handshake: a request is accepted in any cycle where start=1, flush=0 and
// the FSM is IDLE or DONE. mul_ready drops combinationally in that same
// cycle and stays low until the done cycle, so decode stalls on the issue
// cycle itself. start while BUSY is ignored; flush beats a coincident start.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            Rst,
  input  logic            start,
  input  logic [2:0]      mulsel,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            mul_ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      state_dbg
);

  muldiv_state_e         state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
  // Multiply: {high partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [63:0]           acc_q, acc_d;
  logic [31:0]           opd_q, opd_d;     // multiplicand or divisor magnitude
  mulsel_e               op_q, op_d;
  logic                  neg_q, neg_d;
  logic [31:0]           result_q, result_d;
  logic                  done_q, done_d;

  // Request decode
  mulsel_e     sel_in;
  logic        is_div_in;
  logic        a_signed, b_signed;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        neg_in;
  logic        b_zero, sgn_ovf, special;
  logic [31:0] special_res;
  logic        accept;

  always_comb begin
    sel_in    = mulsel_e'(mulsel);
    is_div_in = mulsel[2];
    a_signed  = (sel_in == MS_MULH) || (sel_in == MS_MULHSU) ||
                (sel_in == MS_DIV)  || (sel_in == MS_REM);
    b_signed  = (sel_in == MS_MULH) || (sel_in == MS_DIV) || (sel_in == MS_REM);
    a_neg     = a_signed & op_a[31];
    b_neg     = b_signed & op_b[31];
    a_mag     = abs32(op_a, a_signed);
    b_mag     = abs32(op_b, b_signed);
    // Remainder takes the dividend's sign; everything else the XOR of signs.
    neg_in    = (sel_in == MS_REM) ? a_neg : (a_neg ^ b_neg);

    b_zero    = (op_b == 32'd0);
    sgn_ovf   = ((sel_in == MS_DIV) || (sel_in == MS_REM)) &&
                (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
    special   = is_div_in && (b_zero || sgn_ovf);

    special_res = 32'd0;
    if (b_zero) begin
      special_res = mulsel[1] ? op_a : 32'hFFFF_FFFF;
    end else if (sgn_ovf) begin
      special_res = mulsel[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One iteration step
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [33:0] div_diff;
  logic [63:0] div_next;
  logic [63:0] step_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opd_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};

    // Trial subtract of the divisor from the 33-bit shifted remainder.
    div_diff = {1'b0, acc_q[63:31]} - {2'b00, opd_q};
    if (!div_diff[33]) begin
      div_next = {div_diff[31:0], acc_q[30:0], 1'b1};
    end else begin
      div_next = {acc_q[62:0], 1'b0};
    end

    step_next = op_q[2] ? div_next : mul_next;
  end

  // Final sign fix-up and result selection on the last step
  logic [63:0] prod_fix;
  logic [31:0] div_val;
  logic [31:0] final_res;

  always_comb begin
    prod_fix = neg_q ? (~step_next + 64'd1) : step_next;
    div_val  = op_q[1] ? step_next[63:32] : step_next[31:0];
    if (op_q[2]) begin
      final_res = neg_q ? (~div_val + 32'd1) : div_val;
    end else if (op_q == MS_MUL) begin
      final_res = prod_fix[31:0];
    end else begin
      final_res = prod_fix[63:32];
    end
  end

  // Control FSM
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opd_d    = opd_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    done_d   = 1'b0;
    accept   = 1'b0;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (start) begin
            accept = 1'b1;
            op_d   = sel_in;
            neg_d  = neg_in;
            if (special) begin
              state_d  = DONE;
              cnt_d    = '0;
              result_d = special_res;
              done_d   = 1'b1;
            end else begin
              state_d = BUSY;
              cnt_d   = MD_CNT_W'(MD_STEPS);
              // Multiply keeps b in the low half as the multiplier;
              // divide keeps a there as the dividend.
              acc_d   = {32'd0, is_div_in ? a_mag : b_mag};
              opd_d   = is_div_in ? b_mag : a_mag;
            end
          end
        end
        BUSY: begin
          acc_d = step_next;
          cnt_d = cnt_q - MD_CNT_W'(1);
          if (cnt_q == MD_CNT_W'(1)) begin
            state_d  = DONE;
            result_d = final_res;
            done_d   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opd_q    <= '0;
      op_q     <= MS_MUL;
      neg_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opd_q    <= opd_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign mul_ready = ((state_q == IDLE) || (state_q == DONE)) && !accept;
  assign busy      = (state_q == BUSY);
  assign done      = done_q;
  assign result    = result_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk;
  logic        Rst;
  logic        start;
  logic [2:0]  mulsel;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        mul_ready;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  state_dbg;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp;

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .Rst       (Rst),
    .start     (start),
    .mulsel    (mulsel),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .mul_ready (mul_ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain 64-bit arithmetic following the RISC-V M rules.
  function automatic logic [31:0] ref_model(input logic [2:0] sel,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ua = longint'({32'd0, a});
    longint      ub = longint'({32'd0, b});
    logic [63:0] p;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = 64'd0;
    case (sel)
      3'd0: p = ua * ub;
      3'd1: p = sa * sb;
      3'd2: p = sa * ub;
      3'd3: p = ua * ub;
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb;
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb;
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub;
      end
    endcase
    if (sel == 3'd1 || sel == 3'd2 || sel == 3'd3) return p[63:32];
    return p[31:0];
  endfunction

  function automatic int ref_latency(input logic [2:0] sel,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    if (sel[2] && b == 0) return 1;
    if ((sel == 3'd4 || sel == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Checking
  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Drivers (called just after a negedge)
  task automatic issue(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    start  = 1'b1;
    mulsel = sel;
    op_a   = a;
    op_b   = b;
    #1;
    check({31'd0, mul_ready}, 32'd0, {tag, "_ready_issue"});
    @(posedge clk);
    #1;
    start  = 1'b0;
    // Scramble operand buses to confirm they were captured on acceptance.
    mulsel = 3'($urandom_range(0, 7));
    op_a   = $urandom;
    op_b   = $urandom;
  endtask

  task automatic wait_done(input int exp_lat, input string tag);
    int lat;
    int low_ok;
    logic [31:0] exp_v;
    lat = 0;
    low_ok = 1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      if (mul_ready !== 1'b0) low_ok = 0;
    end
    check(32'(lat), 32'(exp_lat), {tag, "_latency"});
    check(32'(low_ok), 32'd1, {tag, "_ready_low"});
    if (lat != 0) check({31'd0, mul_ready}, 32'd1, {tag, "_ready_done"});
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check(result, exp_v, {tag, "_result"});
    last_exp = exp_v;
  endtask

  task automatic expect_quiet(input int n, input string tag);
    int seen;
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (done !== 1'b0) seen++;
    end
    check(32'(seen), 32'd0, tag);
  endtask

  task automatic run_op(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string tag);
    exp_q.push_back(exp);
    issue(sel, a, b, tag);
    wait_done(lat, tag);
  endtask

  initial begin
    Rst    = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    mulsel = 3'd0;
    op_a   = 32'd0;
    op_b   = 32'd0;
    last_exp = 32'd0;
    repeat (3) @(negedge clk);

    // Reset state
    check(result, 32'd0, "rst_result");
    check({31'd0, done}, 32'd0, "rst_done");
    check({31'd0, busy}, 32'd0, "rst_busy");
    check({31'd0, mul_ready}, 32'd1, "rst_ready");
    check({30'd0, state_dbg}, 32'd0, "rst_state");
    Rst = 1'b1;
    @(negedge clk);

    // Directed operations
    run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_7");
    run_op(3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33, "mulh");
    run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
    run_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, "div_neg");
    run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, "rem_neg");
    run_op(3'd5, 32'd100,        32'd7,         32'd14,        33, "divu");
    run_op(3'd7, 32'd100,        32'd7,         32'd2,         33, "remu");
    run_op(3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,  "div_by0");
    run_op(3'd7, 32'd5,          32'd0,         32'd5,         1,  "remu_by0");
    run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf");
    run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  "rem_ovf");
    @(negedge clk);

    // Flush at cycle 10 of a DIV
    issue(3'd4, 32'd1000, 32'd3, "flush_div");
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check({30'd0, state_dbg}, 32'd0, "flush_state");
    check({31'd0, mul_ready}, 32'd1, "flush_ready");
    check({31'd0, done}, 32'd0, "flush_done");
    check(result, last_exp, "flush_result_held");
    expect_quiet(40, "flush_no_done");

    // start and flush together: request dropped
    start = 1'b1; flush = 1'b1; mulsel = 3'd0; op_a = 32'd9; op_b = 32'd9;
    #1;
    check({31'd0, mul_ready}, 32'd1, "startflush_ready");
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    check({30'd0, state_dbg}, 32'd0, "startflush_state");
    expect_quiet(40, "startflush_no_done");

    // Asynchronous reset in the middle of a MUL
    issue(3'd0, 32'd123, 32'd456, "rst_mid");
    repeat (4) @(negedge clk);
    Rst = 1'b0;
    #1;
    check(result, 32'd0, "rstmid_result");
    check({31'd0, done}, 32'd0, "rstmid_done");
    check({31'd0, busy}, 32'd0, "rstmid_busy");
    check({31'd0, mul_ready}, 32'd1, "rstmid_ready");
    check({30'd0, state_dbg}, 32'd0, "rstmid_state");
    repeat (2) @(negedge clk);
    Rst = 1'b1;
    last_exp = 32'd0;
    expect_quiet(40, "rstmid_no_done");
    run_op(3'd0, 32'd3, 32'd4, 32'd12, 33, "mul_3x4");
    @(negedge clk);

    // Back-to-back with an ignored start during BUSY
    exp_q.push_back(32'd6);
    issue(3'd0, 32'd2, 32'd3, "b2b_mul");
    repeat (9) @(negedge clk);
    start = 1'b1; mulsel = 3'd5; op_a = 32'd100; op_b = 32'd7;
    #1;
    check({31'd0, mul_ready}, 32'd0, "busy_start_ready");
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(24, "b2b_mul");
    run_op(3'd5, 32'd9, 32'd3, 32'd3, 33, "b2b_divu");
    @(negedge clk);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  s;
      logic [31:0] a;
      logic [31:0] b;
      int          pick;
      s = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      pick = $urandom_range(0, 9);
      if (pick == 0) b = 32'd0;
      else if (pick == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (pick == 2) b = 32'($urandom_range(1, 15));
      else if (pick == 3) b = -32'($urandom_range(1, 15));
      run_op(s, a, b, ref_model(s, a, b), ref_latency(s, a, b), "rand");
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
